// File: rtl/reloj_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reloj_pkg
//  Purpose  : Shared glyph codes, glyph widths, default screen positions and
//             a window-test helper for the mm:ss clock overlay.
//  Revision : 1.0  initial release
// ============================================================================
package reloj_pkg;

  typedef logic [3:0] glyph_t;

  localparam glyph_t DIG_COLON = 4'b1010;
  localparam glyph_t DIG_NONE  = 4'b1111;

  localparam int W_DIG = 75;
  localparam int W_COL = 8;

  localparam int X_D3_DEF  = 160;
  localparam int X_D2_DEF  = 250;
  localparam int X_COL_DEF = 340;
  localparam int X_D1_DEF  = 365;
  localparam int X_D0_DEF  = 455;

  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_ONES_MAX = 4'd9;

  // Strict window test, identical to the renderer: left < px < left+width.
  function automatic logic in_window(input logic [10:0] px,
                                     input logic [10:0] left,
                                     input logic [10:0] width);
    return (px > left) && (px < (left + width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_mod60.sv
`default_nettype none
// ============================================================================
//  Module   : contador_mod60
//  Purpose  : Two-digit BCD counter 00..59. inc advances by one; carry is a
//             combinational wrap indication (inc while at 59).
//  Revision : 1.0  initial release
// ============================================================================
module contador_mod60
  import reloj_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_59;

  assign at_59 = (tens_q == BCD_TENS_MAX) && (ones_q == BCD_ONES_MAX);
  assign carry = inc && at_59;

  // Next BCD value: ones roll into tens, 59 rolls to 00
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc) begin
      if (ones_q >= BCD_ONES_MAX) begin
        ones_d = 4'd0;
        tens_d = (tens_q >= BCD_TENS_MAX) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule
`default_nettype wire

// File: rtl/reloj_digitos.sv
`default_nettype none
// ============================================================================
//  Module   : reloj_digitos
//  Purpose  : mm:ss clock with 1 Hz prescaler, set buttons and per-pixel
//             glyph selection (registered, 1-cycle latency) for a renderer.
//  Revision : 1.0  initial release
// ============================================================================
module reloj_digitos
  import reloj_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int X_D3   = X_D3_DEF,
  parameter int X_D2   = X_D2_DEF,
  parameter int X_COL  = X_COL_DEF,
  parameter int X_D1   = X_D1_DEF,
  parameter int X_D0   = X_D0_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic        run_en,
  input  logic        btn_min,
  input  logic        btn_sec,
  output logic [9:0]  posicion,
  output logic [3:0]  digito,
  output logic        digit_valid,
  output logic        tick_1hz,
  output logic [15:0] bcd_time
);

  localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] pre_q;
  logic          tick_q;
  logic          pre_wrap;

  // pre_wrap marks the last cycle of a second; time advances on that edge
  assign pre_wrap = run_en && (pre_q == PRE_MAX);

  // Prescaler (held at 0 in set mode) and registered 1 Hz pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= pre_wrap;
      if (!run_en || pre_wrap) pre_q <= '0;
      else                     pre_q <= pre_q + PW'(1);
    end
  end

  assign tick_1hz = tick_q;

  // Buttons: bit 1 = minutes, bit 0 = seconds
  logic [1:0] btn_s1_q, btn_s2_q, btn_s3_q, btn_arm_q;
  logic [1:0] sync_fill_q;
  logic [1:0] btn_rise;

  // Synchronizer, edge history, and arming: a button must be seen released
  // after reset before a rising edge counts, so a press held through reset
  // deassertion is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1_q    <= 2'b00;
      btn_s2_q    <= 2'b00;
      btn_s3_q    <= 2'b00;
      btn_arm_q   <= 2'b00;
      sync_fill_q <= 2'b00;
    end else begin
      btn_s1_q    <= {btn_min, btn_sec};
      btn_s2_q    <= btn_s1_q;
      btn_s3_q    <= btn_s2_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      btn_arm_q   <= btn_arm_q | ({2{sync_fill_q[1]}} & ~btn_s2_q);
    end
  end

  assign btn_rise = btn_s2_q & ~btn_s3_q & btn_arm_q;

  // Time counters: ticks carry seconds into minutes; buttons never carry
  logic       sec_inc, min_inc, sec_carry, unused_min_carry;
  logic [3:0] sec_tens, sec_ones, min_tens, min_ones;

  assign sec_inc = pre_wrap || (!run_en && btn_rise[0]);
  assign min_inc = pre_wrap ? sec_carry : (!run_en && btn_rise[1]);

  contador_mod60 u_seg (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  contador_mod60 u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (unused_min_carry)
  );

  assign bcd_time = {min_tens, min_ones, sec_tens, sec_ones};

  // Glyph selection
  logic [10:0] px;
  logic        colon_on;
  logic [9:0]  pos_q, pos_d;
  glyph_t      dig_q, dig_d;
  logic        val_q, val_d;

  assign px       = {1'b0, pixel_x};
  assign colon_on = !run_en || (pre_q < PRE_HALF);

  // Decode which glyph window (if any) the current pixel falls in
  always_comb begin
    pos_d = '0;
    dig_d = DIG_NONE;
    val_d = 1'b0;
    if (in_window(px, 11'(X_D3), 11'(W_DIG))) begin
      pos_d = 10'(X_D3); dig_d = min_tens; val_d = 1'b1;
    end else if (in_window(px, 11'(X_D2), 11'(W_DIG))) begin
      pos_d = 10'(X_D2); dig_d = min_ones; val_d = 1'b1;
    end else if (in_window(px, 11'(X_COL), 11'(W_COL))) begin
      if (colon_on) begin
        pos_d = 10'(X_COL); dig_d = DIG_COLON; val_d = 1'b1;
      end
    end else if (in_window(px, 11'(X_D1), 11'(W_DIG))) begin
      pos_d = 10'(X_D1); dig_d = sec_tens; val_d = 1'b1;
    end else if (in_window(px, 11'(X_D0), 11'(W_DIG))) begin
      pos_d = 10'(X_D0); dig_d = sec_ones; val_d = 1'b1;
    end
  end

  // Register glyph outputs (one cycle behind pixel_x)
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
      dig_q <= DIG_NONE;
      val_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dig_q <= dig_d;
      val_q <= val_d;
    end
  end

  assign posicion    = pos_q;
  assign digito      = dig_q;
  assign digit_valid = val_q;

endmodule
`default_nettype wire

// File: tb/tb_reloj_digitos.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reloj_digitos
//  Purpose  : Self-checking bench for reloj_digitos against a seconds-of-hour
//             reference model with arithmetic glyph lookup.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reloj_digitos;

  localparam int CLK_HZ = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_en = 1'b0;
  logic        btn_min = 1'b0;
  logic        btn_sec = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  posicion;
  logic [3:0]  digito;
  logic        digit_valid;
  logic        tick_1hz;
  logic [15:0] bcd_time;

  reloj_digitos #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_x     (pixel_x),
    .run_en      (run_en),
    .btn_min     (btn_min),
    .btn_sec     (btn_sec),
    .posicion    (posicion),
    .digito      (digito),
    .digit_valid (digit_valid),
    .tick_1hz    (tick_1hz),
    .bcd_time    (bcd_time)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed seconds within the hour and prescaler phase
  int         m_sec = 0;
  int         m_pre = 0;
  logic       m_tick = 1'b0;
  logic [9:0] e_pos = '0;
  logic [3:0] e_dig = 4'hF;
  logic       e_val = 1'b0;
  bit         track = 1'b1;
  int         ticks_seen = 0;
  int         xl [5] = '{160, 250, 340, 365, 455};

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic glyph_model(input int px, input int t, input bit run, input int pre,
                             output logic [9:0] pos, output logic [3:0] dig, output logic val);
    logic [15:0] b;
    int w;
    b = to_bcd(t);
    pos = '0; dig = 4'hF; val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = (i == 2) ? 8 : 75;
      if (px > xl[i] && px < xl[i] + w) begin
        if (!(i == 2 && run && pre >= CLK_HZ / 2)) begin
          pos = 10'(xl[i]);
          val = 1'b1;
          case (i)
            0: dig = b[15:12];
            1: dig = b[11:8];
            2: dig = 4'hA;
            3: dig = b[7:4];
            default: dig = b[3:0];
          endcase
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) begin
      m_sec = 0; m_pre = 0; m_tick = 1'b0;
      e_pos = '0; e_dig = 4'hF; e_val = 1'b0;
    end else begin
      glyph_model(pixel_x, m_sec, run_en, m_pre, e_pos, e_dig, e_val);
      if (run_en) begin
        m_tick = (m_pre == CLK_HZ - 1);
        m_pre  = m_tick ? 0 : m_pre + 1;
        if (m_tick) m_sec = (m_sec + 1) % 3600;
      end else begin
        m_tick = 1'b0;
        m_pre  = 0;
      end
    end
    #1;
    if (track) begin
      chk("tick", tick_1hz, m_tick);
      chk("bcd_time", bcd_time, to_bcd(m_sec));
      chk("posicion", posicion, e_pos);
      chk("digito", digito, e_dig);
      chk("digit_valid", digit_valid, e_val);
    end
    if (tick_1hz === 1'b1) ticks_seen++;
  endtask

  // One press: 4 cycles high, 4 cycles low; only counts in set mode
  task automatic press(input bit mn, input bit sc);
    bit apply;
    int m, s;
    apply = !run_en && !reset;
    track = 1'b0;
    btn_min = mn; btn_sec = sc;
    repeat (4) cyc();
    btn_min = 1'b0; btn_sec = 1'b0;
    repeat (4) cyc();
    if (apply) begin
      m = m_sec / 60; s = m_sec % 60;
      if (mn) m = (m + 1) % 60;
      if (sc) s = (s + 1) % 60;
      m_sec = m * 60 + s;
    end
    track = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    int nm;
    int bpx [12] = '{250, 251, 324, 325, 340, 341, 347, 348, 235, 234, 530, 529};

    // Reset state
    do_reset();
    chk("rst_bcd", bcd_time, 16'h0000);
    chk("rst_dig", digito, 4'hF);
    chk("rst_valid", digit_valid, 1'b0);

    // Counting: 600 cycles -> 60 ticks, 01:00
    run_en = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 600; i++) begin
      pixel_x = 10'($urandom_range(150, 540));
      cyc();
    end
    chk("cnt_ticks", ticks_seen, 60);
    chk("cnt_bcd", bcd_time, 16'h0100);
    run_en = 1'b0; pixel_x = '0;
    cyc();

    // Minute wrap: set 59:58, run 20 cycles -> 00:00
    do_reset();
    repeat (58) press(1'b1, 1'b1);
    press(1'b1, 1'b0);
    chk("wrap_set", bcd_time, 16'h5958);
    run_en = 1'b1;
    repeat (10) cyc();
    chk("wrap_1st", bcd_time, 16'h5959);
    repeat (10) cyc();
    chk("wrap_2nd", bcd_time, 16'h0000);
    run_en = 1'b0;
    cyc();

    // Seconds button: 61 presses in set mode, then 61 presses while running
    do_reset();
    nm = int'($urandom_range(1, 9));
    repeat (nm) press(1'b1, 1'b0);
    repeat (61) press(1'b0, 1'b1);
    chk("secbtn_set", bcd_time, to_bcd(nm * 60 + 1));
    run_en = 1'b1;
    repeat (61) press(1'b0, 1'b1);
    chk("secbtn_run", bcd_time, to_bcd(nm * 60 + 1 + 488 / CLK_HZ));
    run_en = 1'b0;
    cyc();

    // Glyph select at 12:34
    do_reset();
    repeat (12) press(1'b1, 1'b1);
    repeat (22) press(1'b0, 1'b1);
    chk("gl_bcd", bcd_time, 16'h1234);
    pixel_x = 10'd255; cyc();
    chk("gl255_pos", posicion, 10'd250);
    chk("gl255_dig", digito, 4'b0010);
    chk("gl255_val", digit_valid, 1'b1);
    pixel_x = 10'd160; cyc();
    chk("gl160_val", digit_valid, 1'b0);
    chk("gl160_dig", digito, 4'hF);
    pixel_x = 10'd344; cyc();
    chk("glcol_set", digito, 4'hA);
    run_en = 1'b1; pixel_x = '0;
    repeat (7) cyc();
    pixel_x = 10'd344; cyc();
    chk("glcol_blink_val", digit_valid, 1'b0);
    chk("glcol_blink_dig", digito, 4'hF);
    run_en = 1'b0;
    foreach (bpx[i]) begin
      pixel_x = bpx[i];
      cyc();
    end
    for (int i = 0; i < 300; i++) begin
      run_en  = ($urandom_range(0, 3) != 0);
      pixel_x = 10'($urandom_range(0, 639));
      cyc();
    end
    run_en = 1'b0; pixel_x = '0;
    cyc();

    // Random set-mode presses
    for (int i = 0; i < 20; i++) begin
      nm = int'($urandom_range(1, 3));
      press(nm[1], nm[0]);
    end
    chk("rand_press", bcd_time, to_bcd(m_sec));

    // Reset mid-run at 05:37 with btn_min held across reset
    do_reset();
    repeat (5) press(1'b1, 1'b0);
    repeat (37) press(1'b0, 1'b1);
    chk("mid_set", bcd_time, 16'h0537);
    run_en = 1'b1;
    repeat (5) cyc();
    btn_min = 1'b1; reset = 1'b1; run_en = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (10) cyc();
    chk("mid_held", bcd_time, 16'h0000);
    btn_min = 1'b0;
    repeat (5) cyc();
    chk("mid_release", bcd_time, 16'h0000);
    press(1'b1, 1'b0);
    chk("mid_after", bcd_time, 16'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
